// File: rtl/uart_apb_initiator.sv
// Two-phase (SETUP/ACCESS) bus initiator for the UART register slave.
// Accepts one request at a time and returns a single-cycle response with a timeout abort.
module uart_apb_initiator #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sel,
  output logic              enable,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sel_nxt, enable_nxt, write_nxt;
  logic               rsp_valid_nxt, rsp_err_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  wdata_nxt, rsp_rdata_nxt;

  // Only the state and reset feed req_ready, keeping it free of any input path.
  assign req_ready = (state == IDLE) & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      enable    <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      enable    <= enable_nxt;
      write     <= write_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    enable_nxt    = enable;
    write_nxt     = write;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_nxt  = req_write;
          addr_nxt   = req_addr;
          wdata_nxt  = req_wdata;
          sel_nxt    = 1'b1;
          enable_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        enable_nxt = 1'b1;
        state_nxt  = ACCESS;
      end
      ACCESS: begin
        if (ready) begin
          sel_nxt       = 1'b0;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = write ? '0 : rdata;
          state_nxt     = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // Slave never answered: abort and report the error with zero data.
          sel_nxt       = 1'b0;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        sel_nxt    = 1'b0;
        enable_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

endmodule
